// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state encodings for the pipelined accumulator ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_HLT = 4'd0;
    localparam logic [OP_W-1:0] OP_SKZ = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_LDA = 4'd5;
    localparam logic [OP_W-1:0] OP_STO = 4'd6;
    localparam logic [OP_W-1:0] OP_JMP = 4'd7;
    localparam logic [OP_W-1:0] OP_SUB = 4'd8;
    localparam logic [OP_W-1:0] OP_OR  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHL = 4'd10;
    localparam logic [OP_W-1:0] OP_SHR = 4'd11;
    localparam logic [OP_W-1:0] OP_MUL = 4'd12;
    localparam logic [OP_W-1:0] OP_ADC = 4'd13;

    localparam int unsigned ST_W = 1;

    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH steps after start.
// done/prod are the combinational view of the final step so the caller can register the result on that edge.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mplier_q;

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod    = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= PW'(a);
            acc_q    <= '0;
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_nxt;
            mcand_q  <= {mcand_q[PW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Accumulator ALU with valid/ready handshake, registered result/flags and optional iterative multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    logic [ST_W-1:0]    state_q, state_d;
    logic [WIDTH-1:0]   res_d;
    logic               z_d, n_d, c_d, v_d, ov_d, ill_d;
    logic [SW-1:0]      sum;
    logic               add_v, sub_v;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready = (state_q == ST_IDLE);
    assign zero     = (accum == '0);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (accum),
        .b     (data),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Shared adder: SUB borrow and ADD/ADC carry both land in sum[WIDTH]
    always_comb begin
        sum = '0;
        case (opcode)
            OP_SUB:  sum = {1'b0, accum} - {1'b0, data};
            OP_ADC:  sum = {1'b0, accum} + {1'b0, data} + SW'(flag_c);
            default: sum = {1'b0, accum} + {1'b0, data};
        endcase
    end

    assign add_v = (accum[MSB] == data[MSB]) && (sum[MSB] != accum[MSB]);
    assign sub_v = (accum[MSB] != data[MSB]) && (sum[MSB] != accum[MSB]);

    always_comb begin
        state_d   = state_q;
        res_d     = alu_out;
        z_d       = flag_z;
        n_d       = flag_n;
        c_d       = flag_c;
        v_d       = flag_v;
        ov_d      = 1'b0;
        ill_d     = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ov_d = 1'b1;
                    v_d  = 1'b0;
                    case (opcode)
                        OP_HLT, OP_SKZ, OP_STO, OP_JMP: res_d = accum;
                        OP_ADD, OP_ADC: begin
                            res_d = sum[MSB:0];
                            c_d   = sum[WIDTH];
                            v_d   = add_v;
                        end
                        OP_SUB: begin
                            res_d = sum[MSB:0];
                            c_d   = sum[WIDTH];
                            v_d   = sub_v;
                        end
                        OP_AND: res_d = accum & data;
                        OP_XOR: res_d = accum ^ data;
                        OP_OR:  res_d = accum | data;
                        OP_LDA: res_d = data;
                        OP_SHL: begin
                            res_d = {accum[MSB-1:0], 1'b0};
                            c_d   = accum[MSB];
                        end
                        OP_SHR: begin
                            res_d = {1'b0, accum[MSB:1]};
                            c_d   = accum[0];
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                ov_d      = 1'b0;
                                v_d       = flag_v;
                                mul_start = 1'b1;
                                state_d   = ST_BUSY;
                            end else begin
                                ill_d = 1'b1;
                                v_d   = flag_v;
                            end
                        end
                        default: begin
                            ill_d = 1'b1;
                            v_d   = flag_v;
                        end
                    endcase
                    if (ov_d && !ill_d) begin
                        z_d = (res_d == '0);
                        n_d = res_d[MSB];
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    res_d   = mul_prod[MSB:0];
                    z_d     = (mul_prod[MSB:0] == '0);
                    n_d     = mul_prod[MSB];
                    c_d     = |mul_prod[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    ov_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            alu_out   <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out   <= res_d;
            flag_z    <= z_d;
            flag_n    <= n_d;
            flag_c    <= c_d;
            flag_v    <= v_d;
            out_valid <= ov_d;
            illegal   <= ill_d;
        end
    end

endmodule
